// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time through IDLE -> READ/WRITE -> RESP,
// with byte/halfword lane merge for sub-word stores and sign/zero extension for loads.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  state_t      state, state_nxt;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        req_err;
  logic        accept;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [31:0] wdata);
    store_merge = old;
    case (f3[1:0])
      2'b00:   store_merge[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_merge[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_merge = wdata;
    endcase
  endfunction

  // Request classification, evaluated on the raw inputs at acceptance
  always_comb begin
    logic legal;
    logic misaligned;
    logic out_of_range;
    if (req_is_store)
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
    req_err      = !legal || misaligned || out_of_range;
  end

  assign accept = req_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = 32'd0;
    mem_addr   = {addr_q[31:2], 2'b00};
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                                   state_nxt = RESP;
          else if (req_is_store && req_funct3 == 3'b010) state_nxt = WRITE;
          else                                           state_nxt = READ;
        end
      end
      READ:  state_nxt = is_store_q ? WRITE : RESP;
      WRITE: begin
        // Gated by rst_n so a reset landing in WRITE never commits a partial store
        mem_write = rst_n;
        mem_wdata = store_merge(funct3_q, addr_q[1:0], word_q, wdata_q);
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      word_q     <= 32'd0;
      resp_rdata <= 32'd0;
      resp_rd    <= 5'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_rd    <= req_rd;
        resp_err   <= req_err;
        resp_rdata <= 32'd0;
      end
      // READ captures the old word for the merge, or produces the load result
      if (state == READ) begin
        word_q <= mem_rdata;
        if (!is_store_q)
          resp_rdata <= load_extend(funct3_q, addr_q[1:0], mem_rdata);
      end
    end
  end

endmodule
